msrv32_reg_block2: RTL and testbench

Stage-2/stage-3 pipeline register of the msrv32 RV32I core. It captures the decoded control fields, operands, PC values and the immediate-adder result from the decode/operand-fetch stage on each rising clock edge. It presents them to the execute/write-back stage one cycle later. The immediate-adder result has its bit 0 conditionally cleared so that taken-branch and jump targets are halfword-aligned.

---
 rtl/msrv32_reg_block2_pkg.sv | 47 ++++
 rtl/msrv32_reg_block2.sv | 86 ++++++++
 tb/tb_msrv32_reg_block2.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/msrv32_reg_block2_pkg.sv
// Shared msrv32 definitions: RV32I field widths, control encodings and the
// branch-target alignment helper used by the stage-2/3 pipeline register.
package msrv32_reg_block2_pkg;

    localparam int XLEN        = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int CSR_ADDR_W  = 12;
    localparam int ALU_OP_W    = 4;
    localparam int WB_SEL_W    = 3;
    localparam int CSR_OP_W    = 3;
    localparam int LOAD_SIZE_W = 2;

    typedef enum logic [WB_SEL_W-1:0] {
        WB_ALU     = 3'b000,
        WB_LU      = 3'b001,
        WB_IMM     = 3'b010,
        WB_IADDER  = 3'b011,
        WB_CSR     = 3'b100,
        WB_PC_PLUS = 3'b101
    } wb_sel_e;

    typedef enum logic [LOAD_SIZE_W-1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10
    } load_size_e;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    // A taken branch/jump target must be halfword aligned, so its LSB is dropped.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] addr,
                                                     input logic            taken);
        return {addr[XLEN-1:1], addr[0] & ~taken};
    endfunction

endpackage

// File: rtl/msrv32_reg_block2.sv
// msrv32 stage-2/stage-3 pipeline register: captures decoded control, operands,
// PC values and the aligned immediate-adder result for execute/write-back.
module msrv32_reg_block2
    import msrv32_reg_block2_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic [REG_ADDR_W-1:0]  rd_addr_in,
    input  logic [CSR_ADDR_W-1:0]  csr_addr_in,
    input  logic [XLEN-1:0]        rs1_in,
    input  logic [XLEN-1:0]        rs2_in,
    input  logic [XLEN-1:0]        pc_in,
    input  logic [XLEN-1:0]        pc_plus_4_in,
    input  logic                   branch_taken_in,
    input  logic [XLEN-1:0]        iadder_in,
    input  logic [ALU_OP_W-1:0]    alu_opcode_in,
    input  logic [LOAD_SIZE_W-1:0] load_size_in,
    input  logic                   load_unsigned_in,
    input  logic                   alu_src_in,
    input  logic                   csr_wr_en_in,
    input  logic                   rf_wr_en_in,
    input  logic [WB_SEL_W-1:0]    wb_mux_sel_in,
    input  logic [CSR_OP_W-1:0]    csr_op_in,
    input  logic [XLEN-1:0]        imm_in,
    output logic [REG_ADDR_W-1:0]  rd_addr_reg_out,
    output logic [CSR_ADDR_W-1:0]  csr_addr_reg_out,
    output logic [XLEN-1:0]        rs1_reg_out,
    output logic [XLEN-1:0]        rs2_reg_out,
    output logic [XLEN-1:0]        pc_reg_out,
    output logic [XLEN-1:0]        pc_plus_4_reg_out,
    output logic [XLEN-1:0]        iadder_out_reg_out,
    output logic [ALU_OP_W-1:0]    alu_opcode_reg_out,
    output logic [LOAD_SIZE_W-1:0] load_size_reg_out,
    output logic                   load_unsigned_reg_out,
    output logic                   alu_src_reg_out,
    output logic                   csr_wr_en_reg_out,
    output logic                   rf_wr_en_reg_out,
    output logic [WB_SEL_W-1:0]    wb_mux_sel_reg_out,
    output logic [CSR_OP_W-1:0]    csr_op_reg_out,
    output logic [XLEN-1:0]        imm_reg_out
);

    logic [XLEN-1:0] iadder_aligned_s;

    assign iadder_aligned_s = align_target(iadder_in, branch_taken_in);

    // Capture every stage-2 field on the same edge; reset clears the whole stage.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            rd_addr_reg_out       <= 5'd0;
            csr_addr_reg_out      <= 12'd0;
            rs1_reg_out           <= 32'd0;
            rs2_reg_out           <= 32'd0;
            pc_reg_out            <= 32'd0;
            pc_plus_4_reg_out     <= 32'd0;
            iadder_out_reg_out    <= 32'd0;
            alu_opcode_reg_out    <= 4'd0;
            load_size_reg_out     <= 2'd0;
            load_unsigned_reg_out <= 1'b0;
            alu_src_reg_out       <= 1'b0;
            csr_wr_en_reg_out     <= 1'b0;
            rf_wr_en_reg_out      <= 1'b0;
            wb_mux_sel_reg_out    <= 3'd0;
            csr_op_reg_out        <= 3'd0;
            imm_reg_out           <= 32'd0;
        end else begin
            rd_addr_reg_out       <= rd_addr_in;
            csr_addr_reg_out      <= csr_addr_in;
            rs1_reg_out           <= rs1_in;
            rs2_reg_out           <= rs2_in;
            pc_reg_out            <= pc_in;
            pc_plus_4_reg_out     <= pc_plus_4_in;
            iadder_out_reg_out    <= iadder_aligned_s;
            alu_opcode_reg_out    <= alu_opcode_in;
            load_size_reg_out     <= load_size_in;
            load_unsigned_reg_out <= load_unsigned_in;
            alu_src_reg_out       <= alu_src_in;
            csr_wr_en_reg_out     <= csr_wr_en_in;
            rf_wr_en_reg_out      <= rf_wr_en_in;
            wb_mux_sel_reg_out    <= wb_mux_sel_in;
            csr_op_reg_out        <= csr_op_in;
            imm_reg_out           <= imm_in;
        end
    end

endmodule

// File: tb/tb_msrv32_reg_block2.sv
// Self-checking bench for msrv32_reg_block2: directed vector table, hold and
// reset sequences, and randomized back-to-back traffic against a field model.
module tb_msrv32_reg_block2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [11:0] csr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        taken;
        logic [31:0] iadder;
        logic [3:0]  aluop;
        logic [1:0]  ls;
        logic        lu;
        logic        src;
        logic        cwe;
        logic        rwe;
        logic [2:0]  wb;
        logic [2:0]  cop;
        logic [31:0] imm;
    } in_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [11:0] csr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] iadder;
        logic [3:0]  aluop;
        logic [1:0]  ls;
        logic        lu;
        logic        src;
        logic        cwe;
        logic        rwe;
        logic [2:0]  wb;
        logic [2:0]  cop;
        logic [31:0] imm;
    } out_t;

    typedef struct {
        string       name;
        in_t         in;
        logic [31:0] exp_iadder;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [4:0]  rd_addr_in;
    logic [11:0] csr_addr_in;
    logic [31:0] rs1_in, rs2_in, pc_in, pc_plus_4_in, iadder_in, imm_in;
    logic        branch_taken_in, load_unsigned_in, alu_src_in, csr_wr_en_in, rf_wr_en_in;
    logic [3:0]  alu_opcode_in;
    logic [1:0]  load_size_in;
    logic [2:0]  wb_mux_sel_in, csr_op_in;

    logic [4:0]  rd_addr_reg_out;
    logic [11:0] csr_addr_reg_out;
    logic [31:0] rs1_reg_out, rs2_reg_out, pc_reg_out, pc_plus_4_reg_out;
    logic [31:0] iadder_out_reg_out, imm_reg_out;
    logic [3:0]  alu_opcode_reg_out;
    logic [1:0]  load_size_reg_out;
    logic        load_unsigned_reg_out, alu_src_reg_out, csr_wr_en_reg_out, rf_wr_en_reg_out;
    logic [2:0]  wb_mux_sel_reg_out, csr_op_reg_out;

    out_t act;
    int   checks = 0;
    int   errors = 0;

    msrv32_reg_block2 dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .rd_addr_in(rd_addr_in), .csr_addr_in(csr_addr_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in), .pc_in(pc_in), .pc_plus_4_in(pc_plus_4_in),
        .branch_taken_in(branch_taken_in), .iadder_in(iadder_in),
        .alu_opcode_in(alu_opcode_in), .load_size_in(load_size_in),
        .load_unsigned_in(load_unsigned_in), .alu_src_in(alu_src_in),
        .csr_wr_en_in(csr_wr_en_in), .rf_wr_en_in(rf_wr_en_in),
        .wb_mux_sel_in(wb_mux_sel_in), .csr_op_in(csr_op_in), .imm_in(imm_in),
        .rd_addr_reg_out(rd_addr_reg_out), .csr_addr_reg_out(csr_addr_reg_out),
        .rs1_reg_out(rs1_reg_out), .rs2_reg_out(rs2_reg_out),
        .pc_reg_out(pc_reg_out), .pc_plus_4_reg_out(pc_plus_4_reg_out),
        .iadder_out_reg_out(iadder_out_reg_out), .alu_opcode_reg_out(alu_opcode_reg_out),
        .load_size_reg_out(load_size_reg_out), .load_unsigned_reg_out(load_unsigned_reg_out),
        .alu_src_reg_out(alu_src_reg_out), .csr_wr_en_reg_out(csr_wr_en_reg_out),
        .rf_wr_en_reg_out(rf_wr_en_reg_out), .wb_mux_sel_reg_out(wb_mux_sel_reg_out),
        .csr_op_reg_out(csr_op_reg_out), .imm_reg_out(imm_reg_out)
    );

    always #5 clk_in = ~clk_in;

    assign act = {rd_addr_reg_out, csr_addr_reg_out, rs1_reg_out, rs2_reg_out,
                  pc_reg_out, pc_plus_4_reg_out, iadder_out_reg_out, alu_opcode_reg_out,
                  load_size_reg_out, load_unsigned_reg_out, alu_src_reg_out,
                  csr_wr_en_reg_out, rf_wr_en_reg_out, wb_mux_sel_reg_out,
                  csr_op_reg_out, imm_reg_out};

    // Reference: every field passes straight through; a taken target loses its odd byte.
    function automatic out_t model(input in_t i);
        out_t o;
        o.rd = i.rd;   o.csr = i.csr; o.rs1 = i.rs1; o.rs2 = i.rs2;
        o.pc = i.pc;   o.pc4 = i.pc4;
        o.iadder = i.taken ? i.iadder - (i.iadder % 32'd2) : i.iadder;
        o.aluop = i.aluop; o.ls = i.ls; o.lu = i.lu; o.src = i.src;
        o.cwe = i.cwe; o.rwe = i.rwe; o.wb = i.wb; o.cop = i.cop; o.imm = i.imm;
        return o;
    endfunction

    function automatic in_t rand_in();
        in_t r;
        r.rd = 5'($urandom);   r.csr = 12'($urandom);
        r.rs1 = $urandom;      r.rs2 = $urandom;
        r.pc = $urandom;       r.pc4 = $urandom;
        r.taken = 1'($urandom); r.iadder = $urandom;
        r.aluop = 4'($urandom); r.ls = 2'($urandom);
        r.lu = 1'($urandom);   r.src = 1'($urandom);
        r.cwe = 1'($urandom);  r.rwe = 1'($urandom);
        r.wb = 3'($urandom);   r.cop = 3'($urandom);
        r.imm = $urandom;
        return r;
    endfunction

    task automatic drive(input in_t i);
        rd_addr_in = i.rd;  csr_addr_in = i.csr; rs1_in = i.rs1; rs2_in = i.rs2;
        pc_in = i.pc;       pc_plus_4_in = i.pc4; branch_taken_in = i.taken;
        iadder_in = i.iadder; alu_opcode_in = i.aluop; load_size_in = i.ls;
        load_unsigned_in = i.lu; alu_src_in = i.src; csr_wr_en_in = i.cwe;
        rf_wr_en_in = i.rwe; wb_mux_sel_in = i.wb; csr_op_in = i.cop; imm_in = i.imm;
    endtask

    task automatic check(input string name, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tv[5];
        in_t   v1, v2, cur;
        out_t  prev_exp, exp;
        out_t  zero;

        zero = '0;
        v1 = '{rd:5'd1, csr:12'h002, rs1:32'h3, rs2:32'h4, pc:32'h100, pc4:32'h104,
               taken:1'b0, iadder:32'h2000, aluop:4'h3, ls:2'b01, lu:1'b0, src:1'b1,
               cwe:1'b0, rwe:1'b1, wb:3'b010, cop:3'b001, imm:32'h1234};
        v2 = '{rd:5'd5, csr:12'h010, rs1:32'hAAAABBBB, rs2:32'hCCCCDDDD, pc:32'h200,
               pc4:32'h204, taken:1'b1, iadder:32'h3000, aluop:4'hA, ls:2'b10, lu:1'b1,
               src:1'b0, cwe:1'b1, rwe:1'b0, wb:3'b100, cop:3'b011, imm:32'hABCD};
        tv[0] = '{"vec1", v1, 32'h0000_2000};
        tv[1] = '{"vec2", v2, 32'h0000_3000};
        tv[2] = '{"lsb_taken", v1, 32'h0000_2000};
        tv[2].in.iadder = 32'h0000_2001; tv[2].in.taken = 1'b1;
        tv[3] = '{"lsb_not_taken", v2, 32'h0000_2001};
        tv[3].in.iadder = 32'h0000_2001; tv[3].in.taken = 1'b0;
        tv[4] = '{"lsb_all_ones", v1, 32'hFFFF_FFFE};
        tv[4].in.iadder = 32'hFFFF_FFFF; tv[4].in.taken = 1'b1;

        // Reset held with busy inputs across several edges.
        reset_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cur = rand_in();
            cur.rs1 = cur.rs1 | 32'h1;
            drive(cur);
            @(posedge clk_in); #1;
            check("reset_hold", zero);
        end

        // Directed table; the previous vector must hold until the capturing edge.
        prev_exp = zero;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            if (k == 0) reset_in = 1'b0;
            drive(tv[k].in);
            #1;
            check({tv[k].name, "_pre_edge"}, prev_exp);
            @(posedge clk_in); #1;
            exp = model(tv[k].in);
            exp.iadder = tv[k].exp_iadder;
            check(tv[k].name, exp);
            prev_exp = exp;
        end

        // Input changes between edges must not reach the outputs.
        @(negedge clk_in);
        cur = rand_in();
        drive(cur);
        @(posedge clk_in); #1;
        exp = model(cur);
        check("hold_capture", exp);
        for (int k = 0; k < 3; k++) begin
            #1 drive(rand_in());
            #1 check("hold_between_edges", exp);
        end

        // Randomized back-to-back traffic.
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_in);
            cur = rand_in();
            drive(cur);
            @(posedge clk_in); #1;
            check("random_b2b", model(cur));
        end

        // Reset asserted mid-cycle after data is loaded clears without an edge.
        @(negedge clk_in);
        cur = rand_in();
        cur.imm = cur.imm | 32'h1;
        drive(cur);
        @(posedge clk_in); #1;
        check("pre_reset_load", model(cur));
        #2 reset_in = 1'b1;
        #1 check("async_clear", zero);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_in);
            drive(rand_in());
            @(posedge clk_in); #1;
            check("reset_mid_hold", zero);
        end
        @(negedge clk_in);
        reset_in = 1'b0;
        cur = rand_in();
        drive(cur);
        #1 check("release_pre_edge", zero);
        @(posedge clk_in); #1;
        check("release_first_capture", model(cur));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
